// File: rtl/memoria_pkg.sv
// Shared types and default sizes for the memoria RAM controller.
package memoria_pkg;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;

endpackage

// File: rtl/memoria_ram_core.sv
// Plain synchronous RAM array: one write port, one registered read port.
module memoria_ram_core
    import memoria_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Array is sampled before the same-edge write lands, so reads are read-first.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/memoria_ram_ctrl.sv
// RAM controller: post-reset clear sweep, read valid flag, auto-increment pointer.
// Optional MEM_WRITE_FIRST_EN: same-cycle write+read returns the new data on q.
module memoria_ram_ctrl
    import memoria_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    input  logic              rden,
    input  logic              auto_inc,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              busy,
    output logic [ADDR_W-1:0] ptr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              q_valid_q, q_valid_d;

    logic [ADDR_W-1:0] ea;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] core_rdata;

    assign ea = auto_inc ? ptr_q : address;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        q_valid_d = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = ea;
        mem_wdata = data;
        unique case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = INIT_VAL;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_IDLE: begin
                mem_we    = wren;
                mem_re    = rden;
                q_valid_d = rden;
                // One step per access even when both wren and rden are set.
                if (auto_inc && (wren || rden)) begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b1;
            q_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            q_valid_q <= q_valid_d;
        end
    end

    memoria_ram_core #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_core (
        .clock(clock),
        .reset(reset),
        .we   (mem_we),
        .re   (mem_re),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(core_rdata)
    );

`ifdef MEM_WRITE_FIRST_EN
    logic              fwd_q, fwd_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

    // Remember whether the last accepted read collided with a write; q holds until the next read.
    always_comb begin
        fwd_d      = fwd_q;
        fwd_data_d = fwd_data_q;
        if (mem_re) begin
            fwd_d      = mem_we;
            fwd_data_d = data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign q = fwd_q ? fwd_data_q : core_rdata;
`else
    assign q = core_rdata;
`endif

    assign q_valid = q_valid_q;
    assign busy    = busy_q;
    assign ptr     = ptr_q;

endmodule

// File: tb/tb_memoria_ram_ctrl.sv
// Self-checking bench for memoria_ram_ctrl: directed plan plus random traffic vs a reference model.
module tb_memoria_ram_ctrl;

    localparam int          DW    = 8;
    localparam int          AW    = 5;
    localparam int          DEPTH = 32;
    localparam logic [7:0]  IV    = 8'hA5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data = '0;
    logic          wren = 1'b0;
    logic          rden = 1'b0;
    logic          auto_inc = 1'b0;
    logic [DW-1:0] q;
    logic          q_valid;
    logic          busy;
    logic [AW-1:0] ptr;

    memoria_ram_ctrl #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .INIT_VAL(IV)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .data    (data),
        .wren    (wren),
        .rden    (rden),
        .auto_inc(auto_inc),
        .q       (q),
        .q_valid (q_valid),
        .busy    (busy),
        .ptr     (ptr)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [7:0] m_mem [DEPTH];
    int         m_sweep = 0;
    bit         m_busy  = 1'b1;
    int         m_ptr   = 0;
    logic [7:0] m_q     = '0;
    bit         m_qv    = 1'b0;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // What the coming rising edge must do, given the inputs now applied.
    task automatic model_edge();
        int         ea;
        logic [7:0] old;
        if (reset) begin
            m_sweep = 0;
            m_busy  = 1'b1;
            m_ptr   = 0;
            m_q     = '0;
            m_qv    = 1'b0;
        end else if (m_busy) begin
            m_mem[m_sweep] = IV;
            m_sweep++;
            if (m_sweep == DEPTH) m_busy = 1'b0;
            m_qv = 1'b0;
        end else begin
            ea  = auto_inc ? m_ptr : int'(address);
            old = m_mem[ea];
            if (wren) m_mem[ea] = data;
            if (rden) begin
                m_q = old;
`ifdef MEM_WRITE_FIRST_EN
                if (wren) m_q = data;
`endif
            end
            m_qv = rden;
            if (auto_inc && (wren || rden)) m_ptr = (m_ptr + 1) % DEPTH;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        chk("q", q, m_q);
        chk("q_valid", q_valid, m_qv);
        chk("busy", busy, m_busy);
        chk("ptr", ptr, m_ptr);
    endtask

    task automatic drive(input bit w, input bit r, input bit a, input int ad, input int d);
        wren     = w;
        rden     = r;
        auto_inc = a;
        address  = AW'(ad);
        data     = DW'(d);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int         n;
        int         p0;
        logic [7:0] q0;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        chk("rst_q", q, 0);
        chk("rst_qv", q_valid, 0);
        chk("rst_busy", busy, 1);
        chk("rst_ptr", ptr, 0);

        // Sweep with a write to addr 7 held during busy
        reset = 1'b0;
        drive(1, 1, 0, 7, 8'h3C);
        count_busy(n);
        chk("busy_cycles", n, DEPTH);
        drive(0, 0, 0, 0, 0);

        // All locations hold INIT_VAL
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, 0, i, 0);
            tick();
            chk("init_q", q, IV);
            chk("init_qv", q_valid, 1);
        end
        drive(0, 0, 0, 0, 0);
        tick();
        chk("qv_drop", q_valid, 0);

        // Move pointer to 30, then burst-write 1..4
        for (int i = 0; i < 30; i++) begin
            drive(0, 1, 1, 0, 0);
            tick();
        end
        chk("ptr_30", ptr, 30);
        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, 1, 0, i);
            tick();
        end
        chk("ptr_wrap", ptr, 2);
        for (int i = 0; i < 28; i++) begin
            drive(0, 1, 1, 0, 0);
            tick();
        end
        chk("ptr_back30", ptr, 30);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 1, 1, 0, 0);
            tick();
            chk("burst_rd", q, i);
        end
        drive(0, 1, 0, 1, 0);
        tick();
        chk("loc1", q, 4);

        // Same-address write+read
        drive(1, 0, 0, 5, 8'h11);
        tick();
        drive(1, 1, 0, 5, 8'h22);
        tick();
`ifdef MEM_WRITE_FIRST_EN
        chk("wr_rd_same", q, 8'h22);
`else
        chk("wr_rd_same", q, 8'h11);
`endif
        drive(0, 1, 0, 5, 0);
        tick();
        chk("rd_after", q, 8'h22);

        // Both wren and rden with auto_inc: single pointer step
        p0 = int'(ptr);
        drive(1, 1, 1, 0, 8'h5A);
        tick();
        chk("ptr_single", ptr, (p0 + 1) % DEPTH);
        q0 = q;
        drive(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("q_hold", q, q0);
            chk("qv_idle", q_valid, 0);
        end

        // Reset from idle with nonzero ptr, then abort a sweep at count 10
        reset = 1'b1;
        tick();
        chk("rst2_ptr", ptr, 0);
        chk("rst2_q", q, 0);
        chk("rst2_qv", q_valid, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy(n);
        chk("busy_restart", n, DEPTH);
        chk("ptr_after_sweep", ptr, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, DEPTH - 1), $urandom_range(0, 255));
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/memoria_ram_ctrl.md
# memoria_ram_ctrl

Parametrised single-port RAM controller, the successor of the fixed 32×8 switch-driven memory. Width and depth are configurable. After reset it clears every location to a known value. It adds a read-enable with a valid flag and an auto-increment address pointer for sequential bursts. It sits between the board-level I/O (switches, keys, hex decoders) and the storage array, presenting registered read data to the display path.

## Interface
- DATA_W, 8, data word width in bits
- ADDR_W, 5, address width; depth is DEPTH = 2**ADDR_W (derived localparam)
- INIT_VAL, 0, DATA_W-bit value written to every location by the post-reset sweep

Ports:
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- address  in  ADDR_W  external address, used when auto_inc=0
- data  in  DATA_W  write data
- wren  in  1  write request
- rden  in  1  read request
- auto_inc  in  1  1: access uses internal pointer ptr instead of address
- q  out  DATA_W  registered read data
- q_valid  out  1  one-cycle pulse: q updated by a read accepted on the previous edge
- busy  out  1  high while the clear sweep runs; requests are ignored
- ptr  out  ADDR_W  current auto-increment pointer

## Operation
- States: ST_INIT (clear sweep), ST_IDLE (normal access).
- Reset: state=ST_INIT, sweep counter=0, ptr=0, q=0, q_valid=0, busy=1.
- ST_INIT: each edge writes INIT_VAL to location counter, then counter+1.
  - After writing DEPTH-1: go to ST_IDLE, busy=0.
  - wren/rden/auto_inc ignored; ptr does not move.
- ST_IDLE: effective address EA = auto_inc ? ptr : address.
  - wren=1: mem[EA] <= data.
  - rden=1: q <= mem[EA]; q_valid=1 next cycle, else q_valid=0.
  - q holds its last value when no read occurs.
- Pointer:
  - Advances exactly once, by 1, when auto_inc=1 and (wren|rden). This holds even if both are set.
  - Wraps DEPTH-1 -> 0.
  - Unchanged when auto_inc=0.
- Simultaneous wren and rden to the same EA: read-first (old data) by default; see Configuration.
- Address arithmetic is modulo DEPTH. There is no out-of-range case.

## Timing
- Read latency: 1 cycle. Request on edge N; q and q_valid are visible after edge N+1 samples, i.e. during cycle N+1.
- Write takes effect on the accepting edge. A read on the following edge returns the new value.
- busy is high for exactly DEPTH cycles after the first edge with reset=0. The first request accepted is in the cycle where busy=0.
- Reset asserted mid-sweep or mid-burst aborts it. The sweep restarts from 0 and ptr returns to 0. Locations already swept keep INIT_VAL; others keep old contents until swept.
- Back-to-back requests accepted every cycle; no stall besides busy.

## Configuration
- MEM_WRITE_FIRST_EN defined: same-cycle wren+rden to the same EA returns data (write-first forwarding) on q.
- Not defined: returns the pre-write contents (read-first). Different-address cases are unaffected.

## Structure
- Shared package memoria_pkg:
  - state enum (ST_INIT, ST_IDLE)
  - default width constants DATA_W_DEF=8, ADDR_W_DEF=5
- Sub-module memoria_ram_core: plain synchronous array, one write port and one registered read port. The controller owns the FSM, sweep counter, pointer, forwarding mux and q_valid.

## Test plan
- Reset released, DATA_W=8, ADDR_W=5, INIT_VAL=8'hA5 -> busy high 32 cycles, then 0. Reading all 32 addresses returns 8'hA5, each with q_valid one cycle after rden.
- While busy: write 8'h3C to addr 7 -> ignored; after sweep, read addr 7 returns INIT_VAL.
- auto_inc=1, four writes 8'h01..8'h04 from ptr=30 -> locations 30,31,0,1 written; ptr=2. Reads from ptr=30 return the same sequence.
- Write 8'h11 to addr 5, then wren+rden to addr 5 with data 8'h22 -> q=8'h11 without MEM_WRITE_FIRST_EN, 8'h22 with it; next read returns 8'h22 either way.
- Reset asserted at sweep count 10 -> busy stays high 32 cycles after release; ptr=0, q=0, q_valid=0.
- auto_inc=1 with wren=rden=1 in one cycle -> ptr advances by 1, not 2. rden=0 for 3 cycles -> q unchanged, q_valid=0.
